// File: rtl/lpgbt_scrambler_pkg.sv
// Shared constants, FSM state type and the frame scramble function for the
// lpGBT 36-bit order-36 scrambler and its matching descrambler.
package lpgbt_scrambler_pkg;

    localparam int FRAME_W = 36;
    localparam int TAP     = 25;

    typedef enum logic {
        WARMUP = 1'b0,
        RUN    = 1'b1
    } state_t;

    // One frame of S = D xnor S(-25) xnor S(-36); the upper bits reuse this frame's low bits.
    function automatic logic [FRAME_W-1:0] scramble36(
        input logic [FRAME_W-1:0] d,
        input logic [FRAME_W-1:0] m
    );
        logic [FRAME_W-1:0] s;
        s[TAP-1:0]       = d[TAP-1:0] ~^ m[FRAME_W-1:FRAME_W-TAP] ~^ m[TAP-1:0];
        s[FRAME_W-1:TAP] = d[FRAME_W-1:TAP] ~^ s[FRAME_W-TAP-1:0] ~^ m[FRAME_W-1:TAP];
        return s;
    endfunction

endpackage

// File: rtl/lpgbt_tmr_voter.sv
// Bitwise 2-of-3 majority voter for triplicated register banks.
module lpgbt_tmr_voter #(
    parameter int W = 1
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic [W-1:0] c,
    output logic [W-1:0] y
);

    assign y = (a & b) | (a & c) | (b & c);

endmodule

// File: rtl/lpgbt_scrambler36_o36.sv
// Transmit-side 36-bit order-36 scrambler with idle warm-up, bypass and realign.
// Optional triplication of all state under SCRAMBLER36_TMR_EN.
module lpgbt_scrambler36_o36
    import lpgbt_scrambler_pkg::*;
#(
    parameter logic [FRAME_W-1:0] SEED          = 36'h0,
    parameter logic [FRAME_W-1:0] IDLE_WORD     = 36'h0,
    parameter int                 WARMUP_FRAMES = 2
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               enable,
    input  logic               bypass,
    input  logic               realign,
    input  logic [FRAME_W-1:0] data,
    output logic [FRAME_W-1:0] scrambledData,
    output logic               ready,
    output logic               warmupActive
);

    localparam int CNT_W = (WARMUP_FRAMES < 1) ? 1 : $clog2(WARMUP_FRAMES + 1);
    localparam int RW    = 2 * FRAME_W + 1 + CNT_W + 2;

    localparam state_t           ST_RST   = (WARMUP_FRAMES == 0) ? RUN : WARMUP;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((WARMUP_FRAMES > 0) ? WARMUP_FRAMES - 1 : 0);
    localparam logic [RW-1:0]    RST_VAL  = {SEED, {FRAME_W{1'b0}}, 1'(ST_RST), {CNT_W{1'b0}},
                                             (WARMUP_FRAMES == 0), (WARMUP_FRAMES != 0)};

    // All state lives in one packed word so it can be triplicated and voted as a unit.
    logic [RW-1:0]      regs_d;
    logic [RW-1:0]      regs_v;
    logic [FRAME_W-1:0] m_v, sd_v, m_d, sd_d;
    logic               state_raw_v;
    state_t             state_v, state_d;
    logic [CNT_W-1:0]   cnt_v, cnt_d;
    logic               ready_v, warm_v, ready_d, warm_d;
    logic [FRAME_W-1:0] din_s, s_s;

    assign {m_v, sd_v, state_raw_v, cnt_v, ready_v, warm_v} = regs_v;
    assign state_v = state_t'(state_raw_v);
    assign din_s   = (state_v == RUN) ? data : IDLE_WORD;
    assign s_s     = scramble36(din_s, m_v);
    assign regs_d  = {m_d, sd_d, 1'(state_d), cnt_d, ready_d, warm_d};

    // Next-state: bypass beats realign; realign scrambles this frame, then reseeds.
    always_comb begin
        m_d     = m_v;
        sd_d    = sd_v;
        state_d = state_v;
        cnt_d   = cnt_v;
        ready_d = ready_v;
        warm_d  = warm_v;
        if (enable) begin
            if (bypass) begin
                sd_d    = data;
                m_d     = SEED;
                state_d = ST_RST;
                cnt_d   = {CNT_W{1'b0}};
            end else begin
                sd_d = s_s;
                m_d  = s_s;
                case (state_v)
                    WARMUP: begin
                        if (cnt_v == CNT_LAST) begin
                            state_d = RUN;
                            cnt_d   = {CNT_W{1'b0}};
                        end else begin
                            cnt_d = cnt_v + CNT_W'(1);
                        end
                    end
                    RUN:     state_d = RUN;
                    default: begin
                        state_d = ST_RST;
                        cnt_d   = {CNT_W{1'b0}};
                    end
                endcase
                if (realign) begin
                    m_d     = SEED;
                    state_d = ST_RST;
                    cnt_d   = {CNT_W{1'b0}};
                end
            end
            ready_d = bypass || (state_d == RUN);
            warm_d  = !bypass && (state_d == WARMUP);
        end else begin
            ready_d = ready_v;
            warm_d  = warm_v;
        end
    end

`ifdef SCRAMBLER36_TMR_EN
    logic [RW-1:0] regs_q, regs_b_q, regs_c_q;

    // Copy A of the state bank.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) regs_q <= RST_VAL;
        else       regs_q <= regs_d;
    end

    // Copy B of the state bank.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) regs_b_q <= RST_VAL;
        else       regs_b_q <= regs_d;
    end

    // Copy C of the state bank.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) regs_c_q <= RST_VAL;
        else       regs_c_q <= regs_d;
    end

    lpgbt_tmr_voter #(.W(RW)) u_voter (
        .a (regs_q),
        .b (regs_b_q),
        .c (regs_c_q),
        .y (regs_v)
    );
`else
    logic [RW-1:0] regs_q;

    // Single state bank.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) regs_q <= RST_VAL;
        else       regs_q <= regs_d;
    end

    assign regs_v = regs_q;
`endif

    assign scrambledData = sd_v;
    assign ready         = ready_v;
    assign warmupActive  = warm_v;

endmodule

// File: tb/tb_lpgbt_scrambler36_o36.sv
// Scoreboard bench: a bit-serial reference model predicts every output frame,
// and a serial descrambler on the monitor side checks loopback of consumed data.
module tb_lpgbt_scrambler36_o36;

    localparam logic [35:0] SEED_P = 36'h9A5C30F6E;
    localparam logic [35:0] IDLE_P = 36'h3C5A96E1B;
    localparam int          WF     = 2;

    logic        clock = 1'b0;
    logic        reset, enable, bypass, realign;
    logic [35:0] data;
    logic [35:0] sd, sd0;
    logic        rdy, warm, rdy0, warm0;

    lpgbt_scrambler36_o36 #(.SEED(SEED_P), .IDLE_WORD(IDLE_P), .WARMUP_FRAMES(WF)) dut (
        .clock(clock), .reset(reset), .enable(enable), .bypass(bypass), .realign(realign),
        .data(data), .scrambledData(sd), .ready(rdy), .warmupActive(warm)
    );

    lpgbt_scrambler36_o36 #(.SEED(36'h0), .IDLE_WORD(36'h0), .WARMUP_FRAMES(0)) dut0 (
        .clock(clock), .reset(reset), .enable(enable), .bypass(bypass), .realign(realign),
        .data(data), .scrambledData(sd0), .ready(rdy0), .warmupActive(warm0)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [35:0] sd;
        logic        rdy;
        logic        warm;
        logic [35:0] din;
        bit          chk_desc;
    } exp_t;

    int   errors = 0;
    int   checks = 0;
    exp_t sbq[$];
    bit   mq[$];
    bit   rxq[$];
    int   warm_left;
    bit   m_chain;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [35:0] rnd36();
        logic [63:0] t;
        t = {$urandom(), $urandom()};
        return t[35:0];
    endfunction

    // Scrambler history as a serial bit stream: index 0 is S(i-36), index 11 is S(i-25).
    function automatic void load_seed();
        logic [35:0] s;
        s  = SEED_P;
        mq = {};
        for (int k = 0; k < 36; k++) mq.push_back(s[k]);
    endfunction

    function automatic logic [35:0] model_scramble(input logic [35:0] d);
        logic [35:0] s;
        bit          b;
        for (int k = 0; k < 36; k++) begin
            b    = ~(~(d[k] ^ mq[11]) ^ mq[0]);
            s[k] = b;
            void'(mq.pop_front());
            mq.push_back(b);
        end
        return s;
    endfunction

    function automatic void model_reset();
        load_seed();
        warm_left = WF;
        m_chain   = 1'b0;
        sbq       = {};
    endfunction

    function automatic void model_strobe(input bit byp, input bit rea, input logic [35:0] d);
        exp_t e;
        e.din      = d;
        e.chk_desc = 1'b0;
        if (byp) begin
            e.sd = d;
            load_seed();
            warm_left = WF;
            m_chain   = 1'b0;
        end else begin
            if (warm_left > 0) begin
                e.sd = model_scramble(IDLE_P);
                warm_left--;
            end else begin
                e.chk_desc = m_chain;
                e.sd       = model_scramble(d);
            end
            m_chain = 1'b1;
            if (rea) begin
                load_seed();
                warm_left = WF;
                m_chain   = 1'b0;
            end
        end
        e.rdy  = byp || (warm_left == 0);
        e.warm = !byp && (warm_left > 0);
        sbq.push_back(e);
    endfunction

    task automatic strobe(input bit byp, input bit rea, input logic [35:0] d, input int gap);
        bypass  = byp;
        realign = rea;
        data    = d;
        enable  = 1'b1;
        model_strobe(byp, rea, d);
        @(posedge clock);
        #1;
        enable  = 1'b0;
        bypass  = 1'b0;
        realign = 1'b0;
        for (int g = 0; g < gap; g++) begin
            @(posedge clock);
            #1;
        end
    endtask

    // Monitor: a frame is presented one clock after each enable strobe.
    bit          fired;
    exp_t        mon_e;
    logic [35:0] desc;

    always @(posedge clock or posedge reset) begin
        if (reset) fired <= 1'b0;
        else       fired <= enable;
    end

    always @(negedge clock) begin
        if (fired) begin
            for (int k = 0; k < 36; k++) begin
                desc[k] = sd[k] ^ rxq[11] ^ rxq[0];
                void'(rxq.pop_front());
                rxq.push_back(sd[k]);
            end
            if (sbq.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL sb_underflow: got an output frame, expected none");
            end else begin
                mon_e = sbq.pop_front();
                check("scrambledData", {28'h0, sd}, {28'h0, mon_e.sd});
                check("ready", {63'h0, rdy}, {63'h0, mon_e.rdy});
                check("warmupActive", {63'h0, warm}, {63'h0, mon_e.warm});
                if (mon_e.chk_desc) check("loopback", {28'h0, desc}, {28'h0, mon_e.din});
            end
        end
    end

    task automatic check_reset_vals(input string tag);
        check({tag, "_sd"}, {28'h0, sd}, 64'h0);
        check({tag, "_ready"}, {63'h0, rdy}, 64'h0);
        check({tag, "_warm"}, {63'h0, warm}, 64'h1);
        check({tag, "_sd0"}, {28'h0, sd0}, 64'h0);
        check({tag, "_ready0"}, {63'h0, rdy0}, 64'h1);
        check({tag, "_warm0"}, {63'h0, warm0}, 64'h0);
    endtask

`ifdef SCRAMBLER36_TMR_EN
    logic [76:0] tmr_v;
`endif

    initial begin
        for (int k = 0; k < 36; k++) rxq.push_back(1'b0);
        enable  = 1'b0;
        bypass  = 1'b0;
        realign = 1'b0;
        data    = 36'h0;
        reset   = 1'b1;
        model_reset();
        #12;
        check_reset_vals("rst");
        @(negedge clock);
        reset = 1'b0;
        @(posedge clock);
        #1;

        // Warm-up with 3-cycle gaps; dut0 gives the first-frame vectors.
        strobe(1'b0, 1'b0, 36'hFFFFFFFFF, 3);
        check("dut0_first", {28'h0, sd0}, 64'h001FFFFFF);
        check("dut0_ready", {63'h0, rdy0}, 64'h1);
        strobe(1'b0, 1'b0, 36'hFFFFFFFFF, 3);
        check("dut0_second", {28'h0, sd0}, 64'h000003FFF);
        for (int i = 0; i < 6; i++) strobe(1'b0, 1'b0, rnd36(), 0);

        // Bypass mid-RUN, bypass+realign, then back to warm-up from SEED.
        strobe(1'b1, 1'b0, rnd36(), 0);
        strobe(1'b1, 1'b1, rnd36(), 1);
        for (int i = 0; i < 5; i++) strobe(1'b0, 1'b0, rnd36(), 0);

        // Realign during RUN.
        strobe(1'b0, 1'b1, rnd36(), 0);
        for (int i = 0; i < 5; i++) strobe(1'b0, 1'b0, rnd36(), 1);

        // Asynchronous reset between strobes.
        #2;
        reset = 1'b1;
        #1;
        check_reset_vals("midrst");
        model_reset();
        #10;
        @(negedge clock);
        reset = 1'b0;
        @(posedge clock);
        #1;

`ifdef SCRAMBLER36_TMR_EN
        for (int i = 0; i < 4; i++) strobe(1'b0, 1'b0, rnd36(), 0);
        tmr_v     = dut.regs_b_q;
        tmr_v[50] = ~tmr_v[50];
        tmr_v[4]  = ~tmr_v[4];
        force dut.regs_b_q = tmr_v;
        for (int i = 0; i < 3; i++) strobe(1'b0, 1'b0, rnd36(), 1);
        release dut.regs_b_q;
`endif

        for (int i = 0; i < 1000; i++) begin
            strobe(($urandom_range(0, 99) < 4), ($urandom_range(0, 99) < 4), rnd36(),
                   $urandom_range(0, 2));
        end

        repeat (3) @(posedge clock);
        #1;
        check("sb_drained", 64'(sbq.size()), 64'h0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
